sram_rr_arbiter: RTL and testbench

SRAM_RR_ARBITER -- requirements
Module: sram_rr_arbiter

---
 rtl/sram_rr_arbiter.sv | 150 +++++++++++++++
 tb/tb_sram_rr_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sram_rr_arbiter
//  Description : Two-port round-robin arbiter in front of a single-port SRAM
//                (OpenRAM-style active-low csb0/web0 interface). Grants are
//                combinational. The SRAM command is registered. Read data
//                returns on a shared rdata bus with a per-port rvalid strobe
//                three cycles after the grant.
//  Ports       : clk, rst                 - clock, synchronous active-high reset
//                a_* / b_*                - requester ports (req, we, addr, wdata)
//                a_gnt / b_gnt            - combinational accept strobes
//                a_rvalid / b_rvalid      - read-data-valid strobes
//                rdata                    - shared registered read data
//                csb0, web0, addr0, din0  - registered SRAM command
//                dout0                    - SRAM read data
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_rr_arbiter #(
    parameter int DATA_WIDTH = 150,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  a_gnt,
    output logic                  b_gnt,
    output logic                  a_rvalid,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  csb0,
    output logic                  web0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] dout0
);

    localparam logic c_PTR_A = 1'b0;
    localparam logic c_PTR_B = 1'b1;

    logic                  r_ptr;
    logic                  w_a_gnt;
    logic                  w_b_gnt;
    logic                  w_any;
    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_wdata;

    logic                  r_csb0;
    logic                  r_web0;
    logic [ADDR_WIDTH-1:0] r_addr0;
    logic [DATA_WIDTH-1:0] r_din0;

    // In-flight read tracker: index 0 = command registered, 1 = SRAM captured
    logic [1:0]            r_rd_vld;
    logic [1:0]            r_rd_port;   // 0 = A, 1 = B
    logic                  r_a_rvalid;
    logic                  r_b_rvalid;
    logic [DATA_WIDTH-1:0] r_rdata;

    // Grant selection; the pointer only matters when both ports request.
    // Grants are forced low during reset so no transaction is accepted.
    always_comb begin
        w_a_gnt = 1'b0;
        w_b_gnt = 1'b0;
        if (!rst) begin
            if (a_req && b_req) begin
                w_a_gnt = (r_ptr == c_PTR_A);
                w_b_gnt = (r_ptr == c_PTR_B);
            end else begin
                w_a_gnt = a_req;
                w_b_gnt = b_req;
            end
        end
    end

    assign w_any   = w_a_gnt | w_b_gnt;
    assign w_we    = w_b_gnt ? b_we    : a_we;
    assign w_addr  = w_b_gnt ? b_addr  : a_addr;
    assign w_wdata = w_b_gnt ? b_wdata : a_wdata;

    // Round-robin pointer: after a grant, favour the other port
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= c_PTR_A;
        end else if (w_a_gnt) begin
            r_ptr <= c_PTR_B;
        end else if (w_b_gnt) begin
            r_ptr <= c_PTR_A;
        end
    end

    // Registered SRAM command; address/data hold when idle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_csb0  <= 1'b1;
            r_web0  <= 1'b1;
            r_addr0 <= '0;
            r_din0  <= '0;
        end else if (w_any) begin
            r_csb0  <= 1'b0;
            r_web0  <= ~w_we;
            r_addr0 <= w_addr;
            if (w_we) begin
                r_din0 <= w_wdata;
            end
        end else begin
            r_csb0  <= 1'b1;
            r_web0  <= 1'b1;
        end
    end

    // Read return path: grant N -> SRAM capture end N+1 -> rdata end N+2,
    // so rvalid is visible in cycle N+3.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_vld   <= 2'b00;
            r_rd_port  <= 2'b00;
            r_a_rvalid <= 1'b0;
            r_b_rvalid <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_rd_vld   <= {r_rd_vld[0], w_any & ~w_we};
            r_rd_port  <= {r_rd_port[0], w_b_gnt};
            r_a_rvalid <= r_rd_vld[1] & ~r_rd_port[1];
            r_b_rvalid <= r_rd_vld[1] &  r_rd_port[1];
            if (r_rd_vld[1]) begin
                r_rdata <= dout0;
            end
        end
    end

    assign a_gnt    = w_a_gnt;
    assign b_gnt    = w_b_gnt;
    assign a_rvalid = r_a_rvalid;
    assign b_rvalid = r_b_rvalid;
    assign rdata    = r_rdata;
    assign csb0     = r_csb0;
    assign web0     = r_web0;
    assign addr0    = r_addr0;
    assign din0     = r_din0;

endmodule
`default_nettype wire

// File: tb/tb_sram_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_rr_arbiter
//  Description : Self-checking bench for sram_rr_arbiter with a behavioural
//                single-port SRAM and a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_rr_arbiter;
    localparam int DW = 150;
    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_req, b_req, a_we, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic          a_gnt, b_gnt, a_rvalid, b_rvalid;
    logic [DW-1:0] rdata;
    logic          csb0, web0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] din0;
    logic [DW-1:0] dout0;

    always #5 clk = ~clk;

    sram_rr_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .a_gnt(a_gnt), .b_gnt(b_gnt), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
        .rdata(rdata), .csb0(csb0), .web0(web0), .addr0(addr0), .din0(din0),
        .dout0(dout0)
    );

    // Behavioural single-port SRAM: captures on the rising edge
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (csb0 == 1'b0) begin
            if (web0 == 1'b0) mem[addr0] <= din0;
            else              dout0      <= mem[addr0];
        end
    end

    // ---------------- reference model ----------------
    typedef struct {
        int            due;
        bit            port;
        logic [DW-1:0] data;
    } rd_t;

    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    bit            m_ptr;          // 0 = A favoured, 1 = B favoured
    bit            m_known = 0;
    logic          m_csb, m_web;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_din, m_rdata;
    logic [DW-1:0] refmem [0:(1<<AW)-1];
    rd_t           q[$];
    logic          s_a_rvalid, s_b_rvalid, s_csb0, s_web0;
    logic [DW-1:0] s_rdata;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    // One clock cycle: inputs already driven; sample at negedge, advance model.
    task automatic step(output logic ga, output logic gb);
        bit            eg_a, eg_b, ev_a, ev_b, we;
        logic [AW-1:0] ad;
        logic [DW-1:0] wd;
        rd_t           r;
        @(negedge clk);
        eg_a = 0; eg_b = 0;
        if (!rst) begin
            if (a_req && b_req) begin
                if (m_ptr) eg_b = 1; else eg_a = 1;
            end else if (a_req) eg_a = 1;
            else if (b_req)     eg_b = 1;
        end
        ga = a_gnt; gb = b_gnt;
        s_a_rvalid = a_rvalid; s_b_rvalid = b_rvalid; s_rdata = rdata;
        s_csb0 = csb0; s_web0 = web0;
        chk("a_gnt", {{(DW-1){1'b0}}, a_gnt}, {{(DW-1){1'b0}}, eg_a});
        chk("b_gnt", {{(DW-1){1'b0}}, b_gnt}, {{(DW-1){1'b0}}, eg_b});
        ev_a = 0; ev_b = 0;
        if (q.size() > 0 && q[0].due == cyc) begin
            r = q.pop_front();
            if (r.port) ev_b = 1; else ev_a = 1;
            m_rdata = r.data;
        end
        if (m_known) begin
            chk("a_rvalid", {{(DW-1){1'b0}}, a_rvalid}, {{(DW-1){1'b0}}, ev_a});
            chk("b_rvalid", {{(DW-1){1'b0}}, b_rvalid}, {{(DW-1){1'b0}}, ev_b});
            chk("rdata", rdata, m_rdata);
            chk("csb0", {{(DW-1){1'b0}}, csb0}, {{(DW-1){1'b0}}, m_csb});
            chk("web0", {{(DW-1){1'b0}}, web0}, {{(DW-1){1'b0}}, m_web});
            chk("addr0", {{(DW-AW){1'b0}}, addr0}, {{(DW-AW){1'b0}}, m_addr});
            chk("din0", din0, m_din);
        end
        // state after the coming edge
        if (rst) begin
            m_known = 1; m_ptr = 0; m_csb = 1; m_web = 1;
            m_addr = '0; m_din = '0; m_rdata = '0;
            q.delete();
        end else if (eg_a || eg_b) begin
            we = eg_a ? a_we : b_we;
            ad = eg_a ? a_addr : b_addr;
            wd = eg_a ? a_wdata : b_wdata;
            m_ptr = eg_a;
            m_csb = 0; m_web = ~we; m_addr = ad;
            if (we) begin
                m_din = wd;
                refmem[ad] = wd;
            end else begin
                q.push_back('{cyc + 3, eg_b, refmem[ad]});
            end
        end else begin
            m_csb = 1; m_web = 1;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive(input bit r, input bit ar, input bit aw, input logic [AW-1:0] aa,
                         input bit br, input bit bw, input logic [AW-1:0] ba,
                         input logic [DW-1:0] wd);
        rst = r; a_req = ar; a_we = aw; a_addr = aa; a_wdata = wd;
        b_req = br; b_we = bw; b_addr = ba; b_wdata = ~wd;
    endtask

    function automatic logic [DW-1:0] rnd_word();
        logic [159:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return t[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] b1(input logic v);
        return {{(DW-1){1'b0}}, v};
    endfunction

    typedef struct {
        bit            r, ar, aw;
        logic [AW-1:0] aa;
        bit            br, bw;
        logic [AW-1:0] ba;
        logic [DW-1:0] wd;
        bit            ega, egb;
    } vec_t;

    vec_t          tbl [0:11];
    logic          ga, gb;
    logic [DW-1:0] ones;
    bit            hold_a, hold_b;

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i] = '0;
            refmem[i] = '0;
        end
        dout0 = '0;
        ones = '1;

        // reset, contention A,B,A,B, single-requester overrides, idle
        tbl[0]  = '{1, 0, 0, 9'h000, 0, 0, 9'h000, '0,       0, 0};
        tbl[1]  = '{1, 1, 0, 9'h001, 1, 0, 9'h002, '0,       0, 0};
        tbl[2]  = '{0, 1, 0, 9'h010, 1, 0, 9'h020, '0,       1, 0};
        tbl[3]  = '{0, 1, 0, 9'h011, 1, 0, 9'h020, '0,       0, 1};
        tbl[4]  = '{0, 1, 0, 9'h011, 1, 0, 9'h021, '0,       1, 0};
        tbl[5]  = '{0, 1, 0, 9'h012, 1, 0, 9'h021, '0,       0, 1};
        tbl[6]  = '{0, 0, 0, 9'h000, 1, 1, 9'h030, 150'h7,   0, 1};
        tbl[7]  = '{0, 0, 0, 9'h000, 1, 1, 9'h031, 150'h9,   0, 1};
        tbl[8]  = '{0, 1, 1, 9'h032, 0, 0, 9'h000, 150'h55,  1, 0};
        tbl[9]  = '{0, 1, 0, 9'h030, 1, 0, 9'h031, '0,       0, 1};
        tbl[10] = '{0, 1, 0, 9'h030, 0, 0, 9'h000, '0,       1, 0};
        tbl[11] = '{0, 0, 0, 9'h000, 0, 0, 9'h000, '0,       0, 0};

        drive(1, 0, 0, '0, 0, 0, '0, '0);
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].r, tbl[i].ar, tbl[i].aw, tbl[i].aa, tbl[i].br, tbl[i].bw, tbl[i].ba, tbl[i].wd);
            step(ga, gb);
            chk("tbl_a_gnt", b1(ga), b1(tbl[i].ega));
            chk("tbl_b_gnt", b1(gb), b1(tbl[i].egb));
        end

        // single write then read on A
        drive(0, 1, 1, 9'h005, 0, 0, '0, ones); step(ga, gb);
        drive(0, 1, 0, 9'h005, 0, 0, '0, '0);   step(ga, gb);
        drive(0, 0, 0, '0, 0, 0, '0, '0);
        for (int k = 0; k < 3; k++) step(ga, gb);
        chk("wr_rd_a_rvalid", b1(s_a_rvalid), b1(1'b1));
        chk("wr_rd_b_rvalid", b1(s_b_rvalid), b1(1'b0));
        chk("wr_rd_rdata", s_rdata, ones);

        // back-to-back B reads, distinct data written first by A
        drive(0, 1, 1, 9'h000, 0, 0, '0, 150'h111); step(ga, gb);
        drive(0, 1, 1, 9'h1FF, 0, 0, '0, 150'h222); step(ga, gb);
        drive(0, 1, 1, 9'h100, 0, 0, '0, 150'h333); step(ga, gb);
        drive(0, 0, 0, '0, 1, 0, 9'h000, '0); step(ga, gb);
        drive(0, 0, 0, '0, 1, 0, 9'h1FF, '0); step(ga, gb);
        drive(0, 0, 0, '0, 1, 0, 9'h100, '0); step(ga, gb);
        drive(0, 0, 0, '0, 0, 0, '0, '0);
        for (int k = 0; k < 3; k++) begin
            step(ga, gb);
            chk("b2b_b_rvalid", b1(s_b_rvalid), b1(1'b1));
            chk("b2b_rdata", s_rdata, (k == 0) ? 150'h111 : (k == 1) ? 150'h222 : 150'h333);
        end

        // write at N, read same address at N+1 returns new data at N+4
        drive(0, 1, 1, 9'h0AA, 0, 0, '0, 150'h1); step(ga, gb);
        drive(0, 0, 0, '0, 1, 0, 9'h0AA, '0);     step(ga, gb);
        drive(0, 0, 0, '0, 0, 0, '0, '0);
        for (int k = 0; k < 3; k++) step(ga, gb);
        chk("raw_b_rvalid", b1(s_b_rvalid), b1(1'b1));
        chk("raw_rdata", s_rdata, 150'h1);

        // reset one cycle after a read grant discards the read
        drive(0, 1, 0, 9'h0AA, 0, 0, '0, '0); step(ga, gb);
        drive(1, 0, 0, '0, 0, 0, '0, '0);     step(ga, gb);
        drive(0, 0, 0, '0, 0, 0, '0, '0);
        for (int k = 0; k < 4; k++) begin
            step(ga, gb);
            chk("rstmid_a_rvalid", b1(s_a_rvalid), b1(1'b0));
            chk("rstmid_csb0", b1(s_csb0), b1(1'b1));
            chk("rstmid_rdata", s_rdata, '0);
        end

        // idle for 10 cycles, then contention must still favour A
        for (int k = 0; k < 10; k++) begin
            step(ga, gb);
            chk("idle_csb0", b1(s_csb0), b1(1'b1));
            chk("idle_web0", b1(s_web0), b1(1'b1));
        end
        drive(0, 1, 0, 9'h003, 1, 0, 9'h004, '0); step(ga, gb);
        chk("idle_ptr_a_gnt", b1(ga), b1(1'b1));

        // randomized traffic; ungranted requests hold their inputs
        hold_a = 0; hold_b = 0;
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 49) == 0);
            if (!hold_a) begin
                a_req = $urandom_range(0, 2) != 0; a_we = $urandom_range(0, 1) != 0;
                a_addr = 9'($urandom_range(0, 15)); a_wdata = rnd_word();
            end
            if (!hold_b) begin
                b_req = $urandom_range(0, 2) != 0; b_we = $urandom_range(0, 1) != 0;
                b_addr = 9'($urandom_range(0, 15)); b_wdata = rnd_word();
            end
            step(ga, gb);
            hold_a = a_req && !ga && !rst;
            hold_b = b_req && !gb && !rst;
        end
        drive(0, 0, 0, '0, 0, 0, '0, '0);
        for (int k = 0; k < 5; k++) step(ga, gb);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
